// File: rtl/colour_decoder_if.sv
// Bundle of the button-side inputs and the decoded-colour handshake outputs.
// The producer of buttons/ready uses master; the decoder uses slave.
interface colour_decoder_if;
    logic       ie;
    logic [3:0] btn;
    logic       ready;
    logic [1:0] colour_dec_out;
    logic       valid;
    logic       multi_err;
    logic       busy;

    modport master (
        output ie,
        output btn,
        output ready,
        input  colour_dec_out,
        input  valid,
        input  multi_err,
        input  busy
    );

    modport slave (
        input  ie,
        input  btn,
        input  ready,
        output colour_dec_out,
        output valid,
        output multi_err,
        output busy
    );
endinterface

// File: rtl/colour_decoder.sv
// Debounced four-button colour decoder: synchronises raw buttons, accepts a
// single stable press, presents its 2-bit code once, then waits for release.
module colour_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    colour_decoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS    = 2'd1;
    localparam logic [1:0] ST_PRESENT      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;
    logic       busy_q, busy_d;

    logic [3:0] btn_s;
    logic       btn_any;
    logic       btn_multi;
    logic       btn_onehot;
    logic [7:0] cnt_inc;

    function automatic logic [1:0] encode_onehot(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    assign sync1_d = bus.btn;
    assign sync2_d = sync1_q;
    assign btn_s   = sync2_q;

    // x & (x-1) clears the lowest set bit; anything left means two or more.
    assign btn_any    = (btn_s != 4'd0);
    assign btn_multi  = ((btn_s & (btn_s - 4'd1)) != 4'd0);
    assign btn_onehot = btn_any && !btn_multi;
    assign cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ie && btn_any) begin
                    if (btn_onehot) begin
                        cap_d   = btn_s;
                        cnt_d   = 8'd1;
                        state_d = ST_DEB_PRESS;
                    end else begin
                        cnt_d   = 8'd0;
                        multi_d = 1'b1;
                        state_d = ST_WAIT_RELEASE;
                    end
                end
            end

            ST_DEB_PRESS: begin
                if (!bus.ie || !btn_any) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (btn_s == cap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        code_d  = encode_onehot(cap_q);
                        valid_d = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (btn_onehot) begin
                    // A different single button restarts the debounce on it.
                    cap_d = btn_s;
                    cnt_d = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                    multi_d = 1'b1;
                    state_d = ST_WAIT_RELEASE;
                end
            end

            ST_PRESENT: begin
                if (bus.ready) begin
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_RELEASE;
                end
            end

            ST_WAIT_RELEASE: begin
                if (btn_any) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = 8'd0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 4'd0;
            code_q  <= 2'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.colour_dec_out = code_q;
    assign bus.valid          = valid_q;
    assign bus.multi_err      = multi_q;
    assign bus.busy           = busy_q;

endmodule
